sdram_init_monitor: RTL and testbench
=====================================

Name: sdram_init_monitor

Overview:
- Device-side responder for the SDRAM command bus driven by the controller's power-up init sequencer.
- Decodes {cs_n, ras_n, cas_n, we_n} plus address each cycle and tracks the JEDEC-style init sequence: power-up wait, PRECHARGE-all, N auto-refreshes, MODE_SET.
- Checks minimum spacing between commands, captures the mode register, and reports ready or a sticky error code.
- Used in simulation benches and as an on-chip protocol checker alongside the controller.

Parameters:
- T_POWERUP, 10000, minimum cycles after reset release before the first non-NOP command.
- T_RP, 1, minimum cycles from PRECHARGE to the next non-NOP command.
- T_RC, 4, minimum cycles from AUTO_REFRESH to the next non-NOP command.
- T_MRD, 2, cycles from MODE_SET until init_done.
- N_REF, 2, minimum AUTO_REFRESH count before MODE_SET.

Ports:
- sys_clk  in  1  clock
- sys_rst  in  1  synchronous, active-high reset
- sdram_cmd  in  4  {cs_n, ras_n, cas_n, we_n}
- sdram_addr  in  13  address bus; A10 is the all-banks bit, A[12:0] is the mode word
- init_done  out  1  init sequence completed legally
- init_err  out  1  sticky protocol violation
- err_code  out  3  first violation cause; 0 means none
- mode_reg  out  13  captured MODE_SET address
- cas_latency  out  3  equals mode_reg[6:4]
- burst_len  out  3  equals mode_reg[2:0]
- ref_cnt  out  4  AUTO_REFRESH commands seen during init, saturating at 15

Behaviour:
- Reset values: every output 0; state POWERUP; gap counter 0.
- Reset is synchronous: asserting sys_rst mid-sequence restarts from POWERUP with all outputs 0, including init_err and mode_reg.
- Command decode:
  - cs_n=1 is DESELECT; DESELECT and NOP (0111) count as idle.
  - PRE=0010, REF=0001, MRS=0000, ACT=0011, RD=0101, WR=0100, BST=0110.
- Gap counter:
  - 16 bits, saturating; increments every cycle.
  - Loads 1 on the cycle after any non-idle command, so it holds the cycle distance since the last command.
  - In POWERUP it counts cycles since reset release.
- States and transitions (all registered, one non-idle command per cycle):
  - POWERUP: idle stays.
    - Non-idle with gap < T_POWERUP -> ERROR, code 1.
    - PRE with A10=1 and gap >= T_POWERUP -> PRE_WAIT.
    - Any other non-idle command -> ERROR, code 2 (this includes PRE with A10=0).
  - PRE_WAIT: non-idle with gap < T_RP -> ERROR, code 3.
    - REF -> REFRESH, ref_cnt=1.
    - Any other non-idle -> ERROR, code 5.
  - REFRESH: non-idle with gap < T_RC -> ERROR, code 4.
    - REF -> ref_cnt+1.
    - MRS with ref_cnt >= N_REF -> MRS_WAIT; capture mode_reg.
    - MRS with ref_cnt < N_REF, or any other command -> ERROR, code 5.
  - MRS_WAIT: idle with gap >= T_MRD -> DONE; init_done=1 from that cycle.
    - Any non-idle before then -> ERROR, code 6.
  - DONE: no timing checks.
    - init_done stays 1.
    - A later MRS recaptures mode_reg.
    - Exits only via reset.
  - ERROR: init_err=1; err_code holds the first cause; init_done=0; absorbing until reset.
- Mode check on capture:
  - mode_reg[6:4] not in {2, 3} -> ERROR, code 7.
  - mode_reg[2:0] not in {0, 1, 2, 3, 7} -> ERROR, code 7.
  - mode_reg is still updated.
- Timing boundaries: a gap exactly equal to the parameter is legal. Example: PRE then REF on the next cycle with T_RP=1 passes.
- init_done and init_err are mutually exclusive.

Test Plan:
1. Nominal sequence: idle 10000 cycles; PRE with A10=1 at cycle 10001; REF at +1; REF at +5; MRS with addr 0x032 at +9; NOPs after.
   -> init_done=1 at MRS+2; mode_reg=0x032; cas_latency=3; burst_len=2; ref_cnt=2; init_err=0.
2. PRE at cycle 9999 -> init_err=1, err_code=1; then sys_rst pulse and nominal rerun -> err cleared, init_done=1.
3. Second REF only 3 cycles after the first -> err_code=4.
   - Separate run, PRE with A10=0 after power-up -> err_code=2.
4. MRS after a single REF -> err_code=5, mode_reg not captured.
   - Separate run, ACT during REFRESH -> err_code=5.
5. MRS with addr 0x052 (CL=5) -> err_code=7, mode_reg=0x052.
   - Separate run, REF one cycle after a legal MRS -> err_code=6.
6. sys_rst asserted one cycle after REF -> all outputs 0 next cycle; a REF issued immediately after reset release -> err_code=1.

Source files
------------

// File: rtl/sdram_init_monitor_if.sv
// SDRAM command/address bus seen by the init monitor.
// Latency: none, plain wires between controller and monitor.
// Backpressure: none, the monitor observes every cycle and never stalls the bus.
interface sdram_init_monitor_if;
    logic [3:0]  sdram_cmd;   // {cs_n, ras_n, cas_n, we_n}
    logic [12:0] sdram_addr;  // A10 = all-banks, A[12:0] = mode word

    modport master (output sdram_cmd, output sdram_addr);
    modport slave  (input  sdram_cmd, input  sdram_addr);
endinterface

// File: rtl/sdram_init_monitor.sv
// Tracks the SDRAM power-up init sequence (PRE-all, N refreshes, MODE_SET) and checks command spacing.
// Latency: status outputs update one cycle after the command that causes them.
// Backpressure: none, purely observes the command bus and accepts one command per cycle.
module sdram_init_monitor #(
    parameter int T_POWERUP = 10000,
    parameter int T_RP      = 1,
    parameter int T_RC      = 4,
    parameter int T_MRD     = 2,
    parameter int N_REF     = 2
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    sdram_init_monitor_if.slave         bus,
    output logic                        init_done,
    output logic                        init_err,
    output logic [2:0]                  err_code,
    output logic [12:0]                 mode_reg,
    output logic [2:0]                  cas_latency,
    output logic [2:0]                  burst_len,
    output logic [3:0]                  ref_cnt
);

    // Mode word layout as driven on A[12:0] during MODE_SET.
    typedef struct packed {
        logic [5:0] rsvd;
        logic [2:0] cas_lat;
        logic       burst_type;
        logic [2:0] burst_len;
    } mode_t;

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_PRE_WAIT,
        ST_REFRESH,
        ST_MRS_WAIT,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    localparam logic [2:0] ERR_EARLY   = 3'd1;
    localparam logic [2:0] ERR_FIRST   = 3'd2;
    localparam logic [2:0] ERR_T_RP    = 3'd3;
    localparam logic [2:0] ERR_T_RC    = 3'd4;
    localparam logic [2:0] ERR_ORDER   = 3'd5;
    localparam logic [2:0] ERR_T_MRD   = 3'd6;
    localparam logic [2:0] ERR_MODE    = 3'd7;

    localparam logic [15:0] GAP_PU  = 16'(T_POWERUP);
    localparam logic [15:0] GAP_RP  = 16'(T_RP);
    localparam logic [15:0] GAP_RC  = 16'(T_RC);
    localparam logic [15:0] GAP_MRD = 16'(T_MRD);
    localparam logic [3:0]  REF_MIN = 4'(N_REF);

    state_t      state_q, state_nxt;
    logic [15:0] gap_q;
    logic [2:0]  code_q, code_nxt;
    logic [3:0]  ref_q, ref_nxt;
    mode_t       mode_q, mode_nxt;

    logic        cmd_idle;
    logic        is_pre, is_ref, is_mrs;
    mode_t       addr_mode;

    // Only CAS latency 2/3 and burst lengths 1/2/4/8/full-page are accepted.
    function automatic logic mode_legal(mode_t m);
        logic cl_ok;
        logic bl_ok;
        cl_ok = (m.cas_lat == 3'd2) || (m.cas_lat == 3'd3);
        bl_ok = (m.burst_len <= 3'd3) || (m.burst_len == 3'd7);
        return cl_ok && bl_ok;
    endfunction

    assign cmd_idle  = bus.sdram_cmd[3] || (bus.sdram_cmd == CMD_NOP);
    assign is_pre    = (bus.sdram_cmd == CMD_PRE);
    assign is_ref    = (bus.sdram_cmd == CMD_REF);
    assign is_mrs    = (bus.sdram_cmd == CMD_MRS);
    assign addr_mode = mode_t'(bus.sdram_addr);

    // Cycle distance since the last real command (or since reset release), saturating.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            gap_q <= 16'd0;
        end else if (!cmd_idle) begin
            gap_q <= 16'd1;
        end else if (gap_q != 16'hFFFF) begin
            gap_q <= gap_q + 16'd1;
        end
    end

    // Sequence state, first error cause, refresh count and captured mode word.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_POWERUP;
            code_q  <= 3'd0;
            ref_q   <= 4'd0;
            mode_q  <= '0;
        end else begin
            state_q <= state_nxt;
            code_q  <= code_nxt;
            ref_q   <= ref_nxt;
            mode_q  <= mode_nxt;
        end
    end

    // Next-state decode; timing violations take precedence over ordering violations.
    always_comb begin
        state_nxt = state_q;
        code_nxt  = code_q;
        ref_nxt   = ref_q;
        mode_nxt  = mode_q;
        case (state_q)
            ST_POWERUP: begin
                if (!cmd_idle) begin
                    if (gap_q < GAP_PU) begin
                        state_nxt = ST_ERROR;
                        code_nxt  = ERR_EARLY;
                    end else if (is_pre && bus.sdram_addr[10]) begin
                        state_nxt = ST_PRE_WAIT;
                    end else begin
                        state_nxt = ST_ERROR;
                        code_nxt  = ERR_FIRST;
                    end
                end
            end
            ST_PRE_WAIT: begin
                if (!cmd_idle) begin
                    if (gap_q < GAP_RP) begin
                        state_nxt = ST_ERROR;
                        code_nxt  = ERR_T_RP;
                    end else if (is_ref) begin
                        state_nxt = ST_REFRESH;
                        ref_nxt   = 4'd1;
                    end else begin
                        state_nxt = ST_ERROR;
                        code_nxt  = ERR_ORDER;
                    end
                end
            end
            ST_REFRESH: begin
                if (!cmd_idle) begin
                    if (gap_q < GAP_RC) begin
                        state_nxt = ST_ERROR;
                        code_nxt  = ERR_T_RC;
                    end else if (is_ref) begin
                        ref_nxt = (ref_q == 4'hF) ? ref_q : ref_q + 4'd1;
                    end else if (is_mrs && (ref_q >= REF_MIN)) begin
                        // The word is captured even when it turns out to be illegal.
                        mode_nxt = addr_mode;
                        if (mode_legal(addr_mode)) begin
                            state_nxt = ST_MRS_WAIT;
                        end else begin
                            state_nxt = ST_ERROR;
                            code_nxt  = ERR_MODE;
                        end
                    end else begin
                        state_nxt = ST_ERROR;
                        code_nxt  = ERR_ORDER;
                    end
                end
            end
            ST_MRS_WAIT: begin
                if (!cmd_idle) begin
                    state_nxt = ST_ERROR;
                    code_nxt  = ERR_T_MRD;
                end else if (gap_q >= GAP_MRD) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // Normal operation: only track later mode register reloads.
                if (is_mrs) begin
                    mode_nxt = addr_mode;
                end
            end
            default: begin
                // ST_ERROR is absorbing until reset.
            end
        endcase
    end

    assign init_done   = (state_q == ST_DONE);
    assign init_err    = (state_q == ST_ERROR);
    assign err_code    = code_q;
    assign mode_reg    = mode_q;
    assign cas_latency = mode_q.cas_lat;
    assign burst_len   = mode_q.burst_len;
    assign ref_cnt     = ref_q;

endmodule

// File: tb/tb_sdram_init_monitor.sv
// Bench for sdram_init_monitor: table of commands with expected status, plus hand-written boundary runs.
// Latency: each command's expected status is compared one clock after it is driven.
// Backpressure: none, the bench drives one command per cycle.
module tb_sdram_init_monitor;

    localparam logic [3:0]  NOP = 4'b0111;
    localparam logic [3:0]  DES = 4'b1111;
    localparam logic [3:0]  PRE = 4'b0010;
    localparam logic [3:0]  REF = 4'b0001;
    localparam logic [3:0]  MRS = 4'b0000;
    localparam logic [3:0]  ACT = 4'b0011;
    localparam logic [12:0] A10 = 13'h0400;
    localparam int          FAST_PU = 20;

    typedef struct packed {
        logic        done;
        logic        err;
        logic [2:0]  code;
        logic [12:0] mode;
        logic [2:0]  cl;
        logic [2:0]  bl;
        logic [3:0]  refc;
    } obs_t;

    typedef struct {
        string       name;
        logic        fast;
        logic        rst;
        logic [3:0]  cmd;
        logic [12:0] addr;
        int          idle;
        obs_t        exp;
    } vec_t;

    logic sys_clk = 1'b0;
    logic sys_rst;
    always #5 sys_clk = ~sys_clk;

    sdram_init_monitor_if bus();

    logic        d_done, d_err, f_done, f_err;
    logic [2:0]  d_code, d_cl, d_bl, f_code, f_cl, f_bl;
    logic [12:0] d_mode, f_mode;
    logic [3:0]  d_ref, f_ref;

    // Default-timing instance for the full power-up runs.
    sdram_init_monitor u_dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .bus         (bus),
        .init_done   (d_done),
        .init_err    (d_err),
        .err_code    (d_code),
        .mode_reg    (d_mode),
        .cas_latency (d_cl),
        .burst_len   (d_bl),
        .ref_cnt     (d_ref)
    );

    // Short power-up instance for the many error scenarios; sees the same bus.
    sdram_init_monitor #(.T_POWERUP(FAST_PU)) u_fast (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .bus         (bus),
        .init_done   (f_done),
        .init_err    (f_err),
        .err_code    (f_code),
        .mode_reg    (f_mode),
        .cas_latency (f_cl),
        .burst_len   (f_bl),
        .ref_cnt     (f_ref)
    );

    vec_t vecs[$];
    obs_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic obs_t mk(logic done, logic err, logic [2:0] code, logic [12:0] mode,
                                logic [2:0] cl, logic [2:0] bl, logic [3:0] refc);
        obs_t o;
        o = {done, err, code, mode, cl, bl, refc};
        return o;
    endfunction

    function automatic void add(string nm, logic fast, logic rst, logic [3:0] cmd,
                                logic [12:0] addr, int idle, obs_t exp);
        vec_t v;
        v.name = nm; v.fast = fast; v.rst = rst; v.cmd = cmd;
        v.addr = addr; v.idle = idle; v.exp = exp;
        vecs.push_back(v);
    endfunction

    function automatic obs_t sample(logic fast);
        if (fast) return {f_done, f_err, f_code, f_mode, f_cl, f_bl, f_ref};
        return {d_done, d_err, d_code, d_mode, d_cl, d_bl, d_ref};
    endfunction

    task automatic check(string nm, obs_t exp, obs_t act);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got done=%0d err=%0d code=%0d mode=%h cl=%0d bl=%0d ref=%0d, expected done=%0d err=%0d code=%0d mode=%h cl=%0d bl=%0d ref=%0d",
                     nm, act.done, act.err, act.code, act.mode, act.cl, act.bl, act.refc,
                     exp.done, exp.err, exp.code, exp.mode, exp.cl, exp.bl, exp.refc);
        end
    endtask

    // Unchecked idle cycles, alternating NOP and DESELECT.
    task automatic idle_cycles(int n);
        for (int k = 0; k < n; k++) begin
            sys_rst        = 1'b0;
            bus.sdram_cmd  = k[0] ? DES : NOP;
            bus.sdram_addr = 13'h0;
            @(posedge sys_clk); #1;
        end
    endtask

    // Drive one command, queue its expectation, compare after the edge.
    task automatic step(string nm, logic fast, logic rst, logic [3:0] cmd, logic [12:0] addr, obs_t exp);
        obs_t got;
        sys_rst        = rst;
        bus.sdram_cmd  = cmd;
        bus.sdram_addr = addr;
        sb.push_back(exp);
        @(posedge sys_clk); #1;
        got = sample(fast);
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            check(nm, sb.pop_front(), got);
        end
    endtask

    // Legal sequence up to init_done; pu_idle idle cycles precede the PRECHARGE.
    function automatic void add_nominal(string tag, logic f, int pu_idle);
        add({tag, "_rst"},   f, 1, NOP, 13'h0,   0,       mk(0, 0, 0, 13'h000, 0, 0, 0));
        add({tag, "_pre"},   f, 0, PRE, A10,     pu_idle, mk(0, 0, 0, 13'h000, 0, 0, 0));
        add({tag, "_ref1"},  f, 0, REF, 13'h0,   0,       mk(0, 0, 0, 13'h000, 0, 0, 1));
        add({tag, "_ref2"},  f, 0, REF, 13'h0,   3,       mk(0, 0, 0, 13'h000, 0, 0, 2));
        add({tag, "_mrs"},   f, 0, MRS, 13'h032, 3,       mk(0, 0, 0, 13'h032, 3, 2, 2));
        add({tag, "_mrs+1"}, f, 0, NOP, 13'h0,   0,       mk(0, 0, 0, 13'h032, 3, 2, 2));
        add({tag, "_mrs+2"}, f, 0, NOP, 13'h0,   0,       mk(1, 0, 0, 13'h032, 3, 2, 2));
    endfunction

    initial begin
        sys_rst        = 1'b1;
        bus.sdram_cmd  = NOP;
        bus.sdram_addr = 13'h0;

        // Default timing: PRE at cycle 9999 is too early, then reset and a full legal run.
        add("early_rst",   0, 1, NOP, 13'h0, 0,    mk(0, 0, 0, 13'h000, 0, 0, 0));
        add("early_pre",   0, 0, PRE, A10,   9998, mk(0, 1, 1, 13'h000, 0, 0, 0));
        add("early_hold",  0, 0, REF, 13'h0, 6,    mk(0, 1, 1, 13'h000, 0, 0, 0));
        add_nominal("nom", 0, 10000);
        add("done_hold",   0, 0, NOP, 13'h0, 5,    mk(1, 0, 0, 13'h032, 3, 2, 2));
        add("done_remrs",  0, 0, MRS, 13'h021, 0,  mk(1, 0, 0, 13'h021, 2, 1, 2));
        add("done_act",    0, 0, ACT, 13'h0, 0,    mk(1, 0, 0, 13'h021, 2, 1, 2));

        // Short power-up: REF spacing below T_RC.
        add("rc_rst",  1, 1, NOP, 13'h0, 0,       mk(0, 0, 0, 0, 0, 0, 0));
        add("rc_pre",  1, 0, PRE, A10,   FAST_PU, mk(0, 0, 0, 0, 0, 0, 0));
        add("rc_ref1", 1, 0, REF, 13'h0, 0,       mk(0, 0, 0, 0, 0, 0, 1));
        add("rc_ref2", 1, 0, REF, 13'h0, 2,       mk(0, 1, 4, 0, 0, 0, 1));
        // PRECHARGE of a single bank as the first command.
        add("a10_rst", 1, 1, NOP, 13'h0, 0,       mk(0, 0, 0, 0, 0, 0, 0));
        add("a10_pre", 1, 0, PRE, 13'h0, FAST_PU, mk(0, 1, 2, 0, 0, 0, 0));
        // MODE_SET after one refresh only.
        add("mrs1_rst", 1, 1, NOP, 13'h0,   0,       mk(0, 0, 0, 0, 0, 0, 0));
        add("mrs1_pre", 1, 0, PRE, A10,     FAST_PU, mk(0, 0, 0, 0, 0, 0, 0));
        add("mrs1_ref", 1, 0, REF, 13'h0,   0,       mk(0, 0, 0, 0, 0, 0, 1));
        add("mrs1_mrs", 1, 0, MRS, 13'h032, 3,       mk(0, 1, 5, 0, 0, 0, 1));
        // ACTIVATE during the refresh phase.
        add("act_rst", 1, 1, NOP, 13'h0, 0,       mk(0, 0, 0, 0, 0, 0, 0));
        add("act_pre", 1, 0, PRE, A10,   FAST_PU, mk(0, 0, 0, 0, 0, 0, 0));
        add("act_ref", 1, 0, REF, 13'h0, 0,       mk(0, 0, 0, 0, 0, 0, 1));
        add("act_act", 1, 0, ACT, 13'h0, 3,       mk(0, 1, 5, 0, 0, 0, 1));
        // Illegal CAS latency 5, word still captured.
        add("cl5_rst",  1, 1, NOP, 13'h0,   0,       mk(0, 0, 0, 0, 0, 0, 0));
        add("cl5_pre",  1, 0, PRE, A10,     FAST_PU, mk(0, 0, 0, 0, 0, 0, 0));
        add("cl5_ref1", 1, 0, REF, 13'h0,   0,       mk(0, 0, 0, 0, 0, 0, 1));
        add("cl5_ref2", 1, 0, REF, 13'h0,   3,       mk(0, 0, 0, 0, 0, 0, 2));
        add("cl5_mrs",  1, 0, MRS, 13'h052, 3,       mk(0, 1, 7, 13'h052, 5, 2, 2));
        // Illegal burst length 4.
        add("bl4_rst",  1, 1, NOP, 13'h0,   0,       mk(0, 0, 0, 0, 0, 0, 0));
        add("bl4_pre",  1, 0, PRE, A10,     FAST_PU, mk(0, 0, 0, 0, 0, 0, 0));
        add("bl4_ref1", 1, 0, REF, 13'h0,   0,       mk(0, 0, 0, 0, 0, 0, 1));
        add("bl4_ref2", 1, 0, REF, 13'h0,   3,       mk(0, 0, 0, 0, 0, 0, 2));
        add("bl4_mrs",  1, 0, MRS, 13'h034, 3,       mk(0, 1, 7, 13'h034, 3, 4, 2));
        // Command during the MODE_SET settle window.
        add("mrd_rst",  1, 1, NOP, 13'h0,   0,       mk(0, 0, 0, 0, 0, 0, 0));
        add("mrd_pre",  1, 0, PRE, A10,     FAST_PU, mk(0, 0, 0, 0, 0, 0, 0));
        add("mrd_ref1", 1, 0, REF, 13'h0,   0,       mk(0, 0, 0, 0, 0, 0, 1));
        add("mrd_ref2", 1, 0, REF, 13'h0,   3,       mk(0, 0, 0, 0, 0, 0, 2));
        add("mrd_mrs",  1, 0, MRS, 13'h032, 3,       mk(0, 0, 0, 13'h032, 3, 2, 2));
        add("mrd_ref3", 1, 0, REF, 13'h0,   0,       mk(0, 1, 6, 13'h032, 3, 2, 2));
        // Reset right after a refresh, then a REF straight out of reset.
        add("mid_rst0", 1, 1, NOP, 13'h0, 0,       mk(0, 0, 0, 0, 0, 0, 0));
        add("mid_pre",  1, 0, PRE, A10,   FAST_PU, mk(0, 0, 0, 0, 0, 0, 0));
        add("mid_ref1", 1, 0, REF, 13'h0, 0,       mk(0, 0, 0, 0, 0, 0, 1));
        add("mid_ref2", 1, 0, REF, 13'h0, 3,       mk(0, 0, 0, 0, 0, 0, 2));
        add("mid_rst",  1, 1, NOP, 13'h0, 0,       mk(0, 0, 0, 0, 0, 0, 0));
        add("mid_refq", 1, 0, REF, 13'h0, 0,       mk(0, 1, 1, 0, 0, 0, 0));
        // Full legal sequence and reset clearing a finished init on the short instance.
        add_nominal("fnom", 1, FAST_PU);
        add("fnom_clr", 1, 1, NOP, 13'h0, 0,       mk(0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            idle_cycles(vecs[i].idle);
            step(vecs[i].name, vecs[i].fast, vecs[i].rst, vecs[i].cmd, vecs[i].addr, vecs[i].exp);
        end

        // Power-up boundary: outputs stay clear while idling, first command at gap T_POWERUP-1 errors.
        step("pu_b_rst", 1, 1, NOP, 13'h0, mk(0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < FAST_PU - 1; k++) begin
            step("pu_b_idle", 1, 0, (k % 2 == 0) ? NOP : DES, 13'h0, mk(0, 0, 0, 0, 0, 0, 0));
        end
        step("pu_b_pre",  1, 0, PRE, A10,     mk(0, 1, 1, 0, 0, 0, 0));
        step("pu_b_absb", 1, 0, MRS, 13'h032, mk(0, 1, 1, 0, 0, 0, 0));

        // PRE then REF on the very next cycle meets T_RP exactly; refreshes keep counting.
        step("rp_rst", 1, 1, NOP, 13'h0, mk(0, 0, 0, 0, 0, 0, 0));
        idle_cycles(FAST_PU);
        step("rp_pre", 1, 0, PRE, A10,   mk(0, 0, 0, 0, 0, 0, 0));
        step("rp_ref", 1, 0, REF, 13'h0, mk(0, 0, 0, 0, 0, 0, 1));
        for (int k = 2; k <= 4; k++) begin
            idle_cycles(3);
            step("rp_refn", 1, 0, REF, 13'h0, mk(0, 0, 0, 0, 0, 0, 4'(k)));
        end

        sys_rst       = 1'b0;
        bus.sdram_cmd = NOP;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
